// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer
//   Captures an NxN signed feature map, walks it in non-overlapping 2x2
//   windows (stride 2, row-major), hands each window to a 2x2 pooling
//   responder over a start/finish handshake and assembles the MxM pooled map.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   go           run request, sampled only in IDLE
//   image_in     NxN map, pixel (i,j) at [(i*N+j)*W +: W]
//   win_out      current window {p11,p10,p01,p00}, p00 in [W-1:0]
//   pool_start   start to pooling responder
//   pool_finish  finish from responder
//   pool_pixel   pooled pixel from responder
//   result_out   MxM pooled map, same packing as image_in
//   busy         run in progress
//   done         one-cycle end-of-run pulse (normal or timeout)
//   error        sticky timeout flag, cleared by reset or the next go
//
// state   | meaning
// IDLE    | waiting for go
// LOAD    | image captured, fetch window (0,0)
// PRESENT | window on win_out one cycle ahead of start
// START   | start asserted, timeout counter cleared
// WAIT_HI | waiting for pool_finish=1, store pixel
// WAIT_LO | waiting for pool_finish=0
// ADVANCE | step to next window or finish
// DONE    | done pulse, drop busy

module pool_window_sequencer #(
  parameter int N       = 5,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [N*N*W-1:0]   image_in,
  output logic [4*W-1:0]     win_out,
  output logic               pool_start,
  input  logic               pool_finish,
  input  logic [W-1:0]       pool_pixel,
  output logic [(N/2)*(N/2)*W-1:0] result_out,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int M  = N / 2;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LOAD, PRESENT, START, WAIT_HI, WAIT_LO, ADVANCE, DONE
  } state_t;

  state_t             state;
  logic [N*N*W-1:0]   img;
  logic [RW-1:0]      r, c, nr, nc;
  logic [CW-1:0]      tcnt;
  logic               last_win;
  logic               tcnt_max;

  function automatic logic [4*W-1:0] window(input logic [N*N*W-1:0] im,
                                            input int wr, input int wc);
    int i0;
    int j0;
    i0 = 2 * wr;
    j0 = 2 * wc;
    return {im[((i0+1)*N + j0 + 1)*W +: W], im[((i0+1)*N + j0)*W +: W],
            im[(i0*N + j0 + 1)*W +: W],     im[(i0*N + j0)*W +: W]};
  endfunction

  always_comb begin
    nr = r;
    nc = c + 1'b1;
    if (c == RW'(M-1)) begin
      nc = '0;
      nr = r + 1'b1;
    end
  end

  assign last_win = (r == RW'(M-1)) && (c == RW'(M-1));
  assign tcnt_max = (tcnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      img        <= '0;
      win_out    <= '0;
      pool_start <= 1'b0;
      result_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      r          <= '0;
      c          <= '0;
      tcnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          img        <= image_in;
          error      <= 1'b0;
          result_out <= '0;
          r          <= '0;
          c          <= '0;
          busy       <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          win_out <= window(img, int'(r), int'(c));
          state   <= PRESENT;
        end
        PRESENT: begin
          pool_start <= 1'b1;
          state      <= START;
        end
        // Later windows arrive here straight from ADVANCE with a fresh
        // win_out, so start rises one cycle after the window settles.
        START: begin
          pool_start <= 1'b1;
          tcnt       <= '0;
          state      <= WAIT_HI;
        end
        WAIT_HI: begin
          if (pool_finish) begin
            result_out[(int'(r)*M + int'(c))*W +: W] <= pool_pixel;
            pool_start <= 1'b0;
            tcnt       <= '0;
            state      <= WAIT_LO;
          end else if (tcnt_max) begin
            error      <= 1'b1;
            pool_start <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        // The timeout budget restarts here: it bounds each finish edge.
        WAIT_LO: begin
          if (!pool_finish) begin
            state <= ADVANCE;
          end else if (tcnt_max) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ADVANCE: begin
          if (last_win) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            r       <= nr;
            c       <= nc;
            win_out <= window(img, int'(nr), int'(nc));
            state   <= START;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_window_sequencer.sv
module tb_pool_window_sequencer;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int TO = 16;
  localparam int M  = N / 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic [N*N*W-1:0]   image_in = '0;
  logic [4*W-1:0]     win_out;
  logic               pool_start;
  logic               pool_finish = 1'b0;
  logic [W-1:0]       pool_pixel = '0;
  logic [M*M*W-1:0]   result_out;
  logic               busy, done, error;

  pool_window_sequencer #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .image_in(image_in),
    .win_out(win_out), .pool_start(pool_start), .pool_finish(pool_finish),
    .pool_pixel(pool_pixel), .result_out(result_out), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M*M*W-1:0] res;
    logic             err;
    int               starts;
  } exp_t;

  exp_t             res_q[$];
  logic [4*W-1:0]   win_q[$];
  time              rise_t[$];
  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int resp_lat = 3;
  int resp_hold = 1;
  bit resp_en = 1'b1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected expected=event", nm);
  endtask

  // Reference model: pure index arithmetic on the image.
  function automatic logic [W-1:0] px(input logic [N*N*W-1:0] im, input int i, input int j);
    return im[(i*N + j)*W +: W];
  endfunction

  function automatic logic [4*W-1:0] model_win(input logic [N*N*W-1:0] im, input int wr, input int wc);
    return {px(im, 2*wr+1, 2*wc+1), px(im, 2*wr+1, 2*wc), px(im, 2*wr, 2*wc+1), px(im, 2*wr, 2*wc)};
  endfunction

  function automatic logic [W-1:0] avg4(input logic [4*W-1:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'($signed(w[k*W +: W]));
    s = s >>> 2;
    return s[W-1:0];
  endfunction

  function automatic logic [N*N*W-1:0] rand_img();
    logic [N*N*W-1:0] im;
    for (int k = 0; k < N*N; k++) im[k*W +: W] = W'($urandom);
    return im;
  endfunction

  task automatic push_exp(input logic [N*N*W-1:0] im, input bit tmo);
    exp_t e;
    e.res = '0;
    e.err = tmo;
    e.starts = tmo ? 1 : M*M;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        if (!tmo || (r == 0 && c == 0)) win_q.push_back(model_win(im, r, c));
        if (!tmo) e.res[(r*M + c)*W +: W] = avg4(model_win(im, r, c));
      end
    res_q.push_back(e);
  endtask

  task automatic issue_run(input logic [N*N*W-1:0] im, input bit tmo);
    push_exp(im, tmo);
    @(negedge clk);
    image_in = im;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    if (!done) fail_now(nm);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy) fail_now("idle_wait");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_starts(input int n);
    int k;
    k = 0;
    while (start_cnt < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (start_cnt < n) fail_now("start_wait");
  endtask

  // Pooling responder: averages the window after resp_lat cycles,
  // holds finish for resp_hold cycles.
  initial begin
    logic [4*W-1:0] w;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && pool_start) begin
        w = win_out;
        repeat (resp_lat) @(negedge clk);
        pool_pixel  = avg4(w);
        pool_finish = 1'b1;
        repeat (resp_hold) @(negedge clk);
        pool_finish = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a window or a done.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pool_start && !prev_start) begin
        start_cnt++;
        rise_t.push_back($time);
        if (win_q.size() == 0) fail_now("unexpected_start");
        else chk("win_out", 128'(win_out), 128'(win_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        if (res_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = res_q.pop_front();
          chk("result_out", 128'(result_out), 128'(e.res));
          chk("error_flag", 128'(error), 128'(e.err));
          chk("start_count", 128'(start_cnt), 128'(e.starts));
        end
        start_cnt = 0;
      end
    end
    prev_start = pool_start;
  end

  initial begin
    logic [N*N*W-1:0] ia, ib;
    logic [M*M*W-1:0] ra, rb;
    time pa, pb;
    int  n, d0;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_start", 128'(pool_start), 0);
    chk("rst_error", 128'(error), 0);
    chk("rst_result", 128'(result_out), 0);
    chk("rst_win", 128'(win_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All pixels 4
    for (int k = 0; k < N*N; k++) ia[k*W +: W] = 16'd4;
    issue_run(ia, 1'b0);
    wait_done(300, "done_const");
    chk("const_result", 128'(result_out), 128'({16'd4, 16'd4, 16'd4, 16'd4}));
    wait_idle();

    // Ramp 5i+j
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) ia[(i*N + j)*W +: W] = W'(5*i + j);
    issue_run(ia, 1'b0);
    wait_done(300, "done_ramp");
    chk("ramp_result", 128'(result_out), 128'({16'd15, 16'd13, 16'd5, 16'd3}));
    wait_idle();

    // Random images, random responder timing (latency 0 = finish already high)
    for (int t = 0; t < 6; t++) begin
      resp_lat  = $urandom_range(0, 4);
      resp_hold = $urandom_range(1, 5);
      issue_run(rand_img(), 1'b0);
      wait_done(400, "done_rand");
      wait_idle();
    end

    // Finish width 1 vs 10
    resp_lat = 3;
    ia = rand_img();
    resp_hold = 1;
    rise_t.delete();
    issue_run(ia, 1'b0);
    wait_done(400, "done_w1");
    ra = result_out;
    pa = rise_t[2] - rise_t[1];
    wait_idle();
    resp_hold = 10;
    rise_t.delete();
    issue_run(ia, 1'b0);
    wait_done(400, "done_w10");
    rb = result_out;
    pb = rise_t[2] - rise_t[1];
    wait_idle();
    chk("width_same_result", 128'(rb), 128'(ra));
    chk("width_period_delta", 128'((pb - pa) / 10), 128'(9));
    resp_hold = 1;

    // go pulsed in WAIT_HI of window 1 is ignored
    ia = rand_img();
    d0 = done_cnt;
    issue_run(ia, 1'b0);
    wait_starts(2);
    image_in = rand_img();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(400, "done_goign");
    repeat (60) @(negedge clk);
    chk("single_done", 128'(done_cnt - d0), 128'(1));
    chk("busy_after_ignore", 128'(busy), 0);

    // go held: back-to-back runs with fresh capture
    ia = rand_img();
    ib = rand_img();
    push_exp(ia, 1'b0);
    push_exp(ib, 1'b0);
    @(negedge clk);
    image_in = ia;
    go = 1'b1;
    @(negedge clk);
    image_in = ib;
    wait_done(400, "done_held1");
    repeat (2) @(negedge clk);
    go = 1'b0;
    chk("held_restart_busy", 128'(busy), 128'(1));
    wait_done(400, "done_held2");
    wait_idle();

    // Timeout: responder silent
    resp_en = 1'b0;
    issue_run(rand_img(), 1'b1);
    n = 0;
    while (!pool_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!pool_start) fail_now("tmo_start");
    n = 0;
    while (!error && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 128'(n), 128'(TO + 1));
    chk("tmo_start_low", 128'(pool_start), 0);
    chk("tmo_done", 128'(done), 128'(1));
    wait_idle();
    chk("tmo_sticky", 128'(error), 128'(1));
    resp_en = 1'b1;

    // Reset during WAIT_HI of window 2, then clean run
    resp_lat = 3;
    issue_run(rand_img(), 1'b0);
    wait_starts(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_start", 128'(pool_start), 0);
    chk("mrst_busy", 128'(busy), 0);
    chk("mrst_result", 128'(result_out), 0);
    chk("mrst_error", 128'(error), 0);
    win_q.delete();
    res_q.delete();
    start_cnt = 0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue_run(rand_img(), 1'b0);
    wait_done(400, "done_after_rst");
    wait_idle();

    chk("res_q_drained", 128'(res_q.size()), 0);
    chk("win_q_drained", 128'(win_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_window_sequencer.md
Name: pool_window_sequencer

Overview:
Initiator side of the pooling start/finish handshake. Captures an NxN shortint feature map, and walks it in non-overlapping 2x2 windows (stride 2) in row-major order. For each window it presents the window to a 2x2 pooling responder, pulses start, collects pixel_out on finish, and assembles the MxM pooled map. It sits between the conv-layer output buffer and the pooling unit.

Parameters:
N, 5, input image side length (N >= 2)
W, 16, pixel width (shortint, signed)
M, N/2 (floor), output side length; an odd trailing row/column is dropped
TIMEOUT, 64, max cycles to wait on any single pool_finish edge (>= 2)

Ports:
clk  in  1  clock, all flops rising-edge
rst_n  in  1  asynchronous active-low reset
go  in  1  request to pool image_in; sampled only in IDLE
image_in  in  N*N*W  input map, row-major, pixel (i,j) at bits [(i*N+j)*W +: W]
win_out  out  4*W  current window {p11,p10,p01,p00}, p00 in bits [W-1:0]
pool_start  out  1  start to pooling responder
pool_finish  in  1  finish from responder, same clock domain
pool_pixel  in  W  pixel_out from responder
result_out  out  M*M*W  pooled map, row-major, same packing as image_in
busy  out  1  high from the cycle after go is accepted until DONE exits
done  out  1  one-cycle pulse at end of run (normal or error)
error  out  1  sticky timeout flag; cleared by reset or the next accepted go

Behaviour:
- Reset (async, rst_n=0): state=IDLE. win_out, pool_start, result_out, busy, done, error and all counters = 0. Takes effect mid-operation with no completion.
- States: IDLE, LOAD, PRESENT, START, WAIT_HI, WAIT_LO, ADVANCE, DONE.
- IDLE: go=1 -> LOAD. Capture image_in into the internal buffer, clear error, clear result_out, r=c=0, busy=1. go is ignored in every other state.
- LOAD -> PRESENT: register win_out = pixels (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1) from the captured buffer.
- PRESENT -> START: pool_start=1. The window is stable for at least 1 cycle before the start rising edge.
- START -> WAIT_HI: clear the timeout counter.
- WAIT_HI: when pool_finish=1, write pool_pixel into result_out[r*M+c] and drive pool_start=0 on that edge -> WAIT_LO.
- WAIT_LO: when pool_finish=0 -> ADVANCE.
- win_out and pool_start are held constant throughout WAIT_HI.
- ADVANCE: c==M-1 ? (c=0, r=r+1) : c=c+1. If the last window is done (r==M-1, c==M-1) -> DONE. Otherwise load the next win_out -> START.
- Minimum window period: 4 cycles plus responder latency.
- Timeout: the counter increments each cycle in WAIT_HI and WAIT_LO. On reaching TIMEOUT: error=1, pool_start=0, go to DONE. result_out keeps the windows completed so far; the rest stay 0.
- DONE: done=1 for exactly one cycle, busy=0 on exit -> IDLE. result_out is held until the next accepted go.
- Arithmetic: none; pool_pixel is stored verbatim (no rounding or sign change).
- Boundaries:
  - pool_finish already 1 in START: still wait for WAIT_HI sampling; accepted on the first WAIT_HI cycle.
  - pool_finish never returning low: covered by the timeout.
  - go held high continuously: after DONE->IDLE a new run starts on the next cycle with a fresh image capture.
  - N odd: row/column N-1 is never read.

Test Plan:
- All pixels = 4, responder averages with 3-cycle latency -> result_out all 4, done pulses once, error=0, exactly M*M=4 pool_start pulses.
- Ramp image pixel(i,j)=5i+j (N=5) -> win_out sequence {6,5,1,0},{8,7,3,2},{16,15,11,10},{18,17,13,12}; results 3,5,13,15 in row-major order.
- Responder never asserts finish, TIMEOUT=16 -> at cycle 16 of WAIT_HI: error=1, pool_start=0, done pulse, result_out=0, then IDLE.
- go pulsed in WAIT_HI of window 1 -> ignored, run completes normally with the original image, and a second done is never produced.
- rst_n dropped during WAIT_HI of window 2 -> same cycle pool_start=0, busy=0, result_out=0. After release, a go starts a clean run from window (0,0).
- Responder finish width 1 cycle versus held 10 cycles -> identical result_out; window period grows by 9 cycles.
